midi_tx: RTL and testbench
==========================

Name: midi_tx

Overview:
- Serial MIDI transmitter: encodes one MIDI message per handshake onto a 31250-baud, 8N1 UART line.
- Counterpart to the MIDI receiver path in SoundModule.
- Used for MIDI THRU/OUT and to loop synth-generated note events back into MIDI_RX on the bench.
- Message length is derived from the status byte. Bytes go out back-to-back, LSB first.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 31250: line rate. Localparam CLKS_PER_BIT = CLK_HZ/BAUD (1600 at defaults).
- GAP_BITS, 0: idle bit-times inserted after each complete message (0..15).

Ports:
- CLOCK_50, in, 1: system clock; all logic on the rising edge.
- RESET_N, in, 1: synchronous, active-low reset.
- msg_valid, in, 1: a message is presented on msg_status/msg_data1/msg_data2.
- msg_ready, out, 1: block can accept a message. Transfer occurs on a cycle where msg_valid && msg_ready.
- msg_status, in, 8: status byte. Bit 7 must be 1.
- msg_data1, in, 8: first data byte. Bit 7 is forced to 0 on transmit.
- msg_data2, in, 8: second data byte. Bit 7 is forced to 0 on transmit.
- MIDI_TX, out, 1: serial line. Idle high.
- busy, out, 1: high from acceptance until the last stop bit (plus gap) completes.
- byte_done, out, 1: one-cycle pulse at the end of each stop bit.
- err, out, 1: one-cycle pulse when an accepted message has msg_status[7]=0.

Behaviour:
- Reset (RESET_N low at a clock edge):
  - MIDI_TX=1, msg_ready=0, busy=0, byte_done=0, err=0.
  - FSM goes to IDLE and all counters clear.
  - msg_ready rises the first cycle after RESET_N is sampled high.
  - Reset mid-frame aborts immediately. The line returns high on the same edge and no partial byte is resumed.
- Length decode, captured at acceptance:
  - 0x80-0xBF, 0xE0-0xEF: 3 bytes.
  - 0xC0-0xDF: 2 bytes.
  - 0xF0-0xFF: 1 byte (status only; system common data is not supported).
- msg_status[7]=0: the message is accepted (msg_ready drops for one cycle), err pulses on the cycle after acceptance, nothing is transmitted, and the FSM returns to IDLE.
- All three input bytes are registered at acceptance. Inputs may change afterwards without effect.
- FSM states: IDLE -> START -> DATA -> STOP -> (next byte ? START : GAP/IDLE).
  - IDLE: msg_ready=1, MIDI_TX=1. On handshake, latch the bytes, set the byte count, go to START next edge.
  - START: MIDI_TX=0 for exactly CLKS_PER_BIT cycles. The first low cycle is the cycle after acceptance (latency 1).
  - DATA: 8 bits LSB first, each exactly CLKS_PER_BIT cycles. A 3-bit index wraps 7->0 and exits to STOP.
  - STOP: MIDI_TX=1 for CLKS_PER_BIT cycles. byte_done pulses on the final cycle. The byte counter decrements.
  - GAP: MIDI_TX=1 for GAP_BITS*CLKS_PER_BIT cycles. Skipped when GAP_BITS=0.
- The bit-timer counter is wide enough for CLKS_PER_BIT-1 and reloads at each bit boundary. There is no drift across bytes.
- Bytes within a message are contiguous: the stop bit is followed directly by the next start bit.
- msg_ready=0 in every state except IDLE. msg_valid is ignored while not ready, so there is no queueing.
- busy = !msg_ready, except on the reset cycle.
- Total message time: N bytes * 10 * CLKS_PER_BIT + GAP_BITS*CLKS_PER_BIT. msg_ready returns on the next cycle.

Optional Feature:
- Macro: MIDI_TX_RUNNING_STATUS_EN.
- Defined:
  - A register holds the last transmitted channel status (0x80-0xEF). It is cleared to 0 on reset.
  - A channel message whose status equals this register is sent without its status byte (2->1 or 3->2 bytes).
  - Any 0xF0-0xF7 status clears the register. 0xF8-0xFF (realtime) leaves it unchanged.
  - An err message leaves it unchanged.
- Undefined: the status byte is always sent and the register is not synthesised.

Test Plan:
- Reset, then send status 0x90, data1 0x3C, data2 0x64 -> MIDI_TX frames 0x90, 0x3C, 0x64 LSB first. Each bit lasts 1600 cycles; the first low is 1 cycle after handshake. 3 byte_done pulses; msg_ready returns after 48000 cycles.
- Send 0xC5, 0x12 (data2 = 0xFF) -> only 2 bytes are sent (32000 cycles) and data2 is ignored. Then 0xF8 -> a single byte in 16000 cycles.
- Send data1=0xBC with status 0x80 -> the transmitted data1 byte is 0x3C (bit 7 cleared).
- Send status 0x45 -> err pulses once, MIDI_TX stays high, msg_ready returns within 2 cycles.
- Assert RESET_N=0 during the 5th data bit of byte 2 -> MIDI_TX=1 and busy=0 on that edge. After release, a new 0x90 message transmits cleanly.
- With MIDI_TX_RUNNING_STATUS_EN: send 0x90/3C/64, 0x90/3E/64, 0xF8, 0x90/40/64 -> the 2nd and 4th messages are 2 bytes each. A following 0xF6 then 0x90/40/64 -> 3 bytes.

Source files
------------

// File: rtl/midi_tx_if.sv
// midi_tx_if: message handshake bundle for the MIDI transmitter.
// master drives a message, slave (midi_tx) returns msg_ready.
interface midi_tx_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;

  modport master (
    output msg_valid, msg_status, msg_data1, msg_data2,
    input  msg_ready
  );

  modport slave (
    input  msg_valid, msg_status, msg_data1, msg_data2,
    output msg_ready
  );
endinterface

// File: rtl/midi_tx.sv
// midi_tx: one MIDI message per handshake onto an 8N1 UART line, LSB first.
// Define MIDI_TX_RUNNING_STATUS_EN to drop repeated channel status bytes.
module midi_tx #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 31250,
  parameter int GAP_BITS = 0
) (
  input  logic     CLOCK_50,
  input  logic     RESET_N,
  midi_tx_if.slave msg,
  output logic     MIDI_TX,
  output logic     busy,
  output logic     byte_done,
  output logic     err
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, GAP
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [3:0]    gap_q;
  logic [1:0]    left_q;
  logic [7:0]    cur_q, nx1_q, nx2_q;
  logic          tx_q, rdy_q, busy_q;
  logic          done_q, err_q;

  logic [1:0] len_d;
  logic [7:0] b0_d, b1_d, b2_d;
  logic       skip_d;
  logic       unused_d;

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] rs_q;
`endif

  assign unused_d = ^{msg.msg_data1[7], msg.msg_data2[7]};

  always_comb begin
    len_d = 2'd3;
    unique case (1'b1)
      msg.msg_status[7:4] == 4'hF:   len_d = 2'd1;
      msg.msg_status[7:5] == 3'b110: len_d = 2'd2;
      default:                       len_d = 2'd3;
    endcase
    skip_d = 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    skip_d = (msg.msg_status[7:4] != 4'hF) &&
             (msg.msg_status == rs_q);
`endif
    b0_d = msg.msg_status;
    b1_d = {1'b0, msg.msg_data1[6:0]};
    b2_d = {1'b0, msg.msg_data2[6:0]};
    if (skip_d) begin
      b0_d  = b1_d;
      b1_d  = b2_d;
      len_d = len_d - 2'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      left_q  <= '0;
      cur_q   <= '0;
      nx1_q   <= '0;
      nx2_q   <= '0;
      tx_q    <= 1'b1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      rs_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          bit_q  <= '0;
          if (msg.msg_valid && rdy_q) begin
            rdy_q  <= 1'b0;
            busy_q <= 1'b1;
            if (!msg.msg_status[7]) begin
              err_q <= 1'b1;
            end else begin
              state_q <= START;
              tx_q    <= 1'b0;
              cur_q   <= b0_d;
              nx1_q   <= b1_d;
              nx2_q   <= b2_d;
              left_q  <= len_d;
`ifdef MIDI_TX_RUNNING_STATUS_EN
              // realtime (F8-FF) must not break running status
              if (msg.msg_status[7:4] != 4'hF)
                rs_q <= msg.msg_status;
              else if (!msg.msg_status[3])
                rs_q <= '0;
`endif
            end
          end
        end
        START: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= DATA;
            tx_q    <= cur_q[0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
              done_q  <= (LAST == '0);
            end else begin
              tx_q <= cur_q[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            cnt_q  <= '0;
            left_q <= left_q - 2'd1;
            if (left_q != 2'd1) begin
              state_q <= START;
              tx_q    <= 1'b0;
              cur_q   <= nx1_q;
              nx1_q   <= nx2_q;
            end else if (GAP_BITS != 0) begin
              state_q <= GAP;
              gap_q   <= '0;
            end else begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= (cnt_q == LAST - 1'b1);
          end
        end
        GAP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (gap_q == GAP_LAST) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              gap_q <= gap_q + 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign msg.msg_ready = rdy_q;
  assign MIDI_TX       = tx_q;
  assign busy          = busy_q;
  assign byte_done     = done_q;
  assign err           = err_q;
endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: random and directed MIDI messages checked against
// a byte-list / waveform reference model of the 8N1 line.
module tb_midi_tx;
  localparam int CLK_HZ = 500000;
  localparam int BAUD   = 31250;
  localparam int GAP    = 2;
  localparam int C      = CLK_HZ / BAUD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy, bdone, err;

  midi_tx_if mif ();

  midi_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .GAP_BITS(GAP)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .msg(mif.slave),
    .MIDI_TX(tx),
    .busy(busy),
    .byte_done(bdone),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] rs = 8'h00;
  logic [7:0] exp_q[$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  // expected on-wire byte list for one message
  task automatic model(input logic [7:0] s, d1, d2);
    int len;
    bit send_st;
    exp_q = {};
    if (!s[7]) return;
    if (s >= 8'hF0) len = 1;
    else if (s >= 8'hC0 && s < 8'hE0) len = 2;
    else len = 3;
    send_st = 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    send_st = !((s < 8'hF0) && (s == rs));
    if (s < 8'hF0) rs = s;
    else if (s < 8'hF8) rs = 8'h00;
`endif
    if (send_st) exp_q.push_back(s);
    if (len > 1) exp_q.push_back(d1 & 8'h7F);
    if (len > 2) exp_q.push_back(d2 & 8'h7F);
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (mif.msg_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", mif.msg_ready, 1);
  endtask

  task automatic handshake(input logic [7:0] s, d1, d2);
    wait_ready();
    mif.msg_valid  = 1'b1;
    mif.msg_status = s;
    mif.msg_data1  = d1;
    mif.msg_data2  = d2;
    @(posedge clk);
    #1;
    mif.msg_valid  = 1'b0;
    mif.msg_status = 8'($urandom);
    mif.msg_data1  = 8'($urandom);
    mif.msg_data2  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] s, d1, d2,
                      input string tag);
    int n, T, mism, nd, bad_done, bad_hs, bad_err, idx, f;
    logic e;
    logic [7:0] got;
    logic wav[$];
    model(s, d1, d2);
    n = exp_q.size();
    handshake(s, d1, d2);
    if (n == 0) begin
      @(negedge clk);
      check({tag, "_err1"}, err, 1);
      check({tag, "_rdy1"}, mif.msg_ready, 0);
      check({tag, "_busy1"}, busy, 1);
      check({tag, "_tx1"}, tx, 1);
      @(negedge clk);
      check({tag, "_err2"}, err, 0);
      check({tag, "_rdy2"}, mif.msg_ready, 1);
      check({tag, "_tx2"}, tx, 1);
      return;
    end
    T = n * 10 * C + GAP * C;
    nd = 0; bad_done = 0; bad_hs = 0; bad_err = 0;
    wav = {};
    for (int k = 1; k <= T; k++) begin
      @(negedge clk);
      wav.push_back(tx);
      if (mif.msg_ready !== 1'b0 || busy !== 1'b1) bad_hs++;
      if (err !== 1'b0) bad_err++;
      if (bdone === 1'b1) begin
        nd++;
        if ((k % (10 * C)) != 0 || k > n * 10 * C) bad_done++;
      end
    end
    @(negedge clk);
    check({tag, "_rdy_ret"}, mif.msg_ready, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_ndone"}, nd, n);
    check({tag, "_done_pos"}, bad_done, 0);
    check({tag, "_hs_busy"}, bad_hs, 0);
    check({tag, "_no_err"}, bad_err, 0);
    mism = 0;
    for (int k = 1; k <= T; k++) begin
      idx = (k - 1) / C;
      if (idx < n * 10) begin
        f = idx % 10;
        if (f == 0) e = 1'b0;
        else if (f == 9) e = 1'b1;
        else e = exp_q[idx / 10][f - 1];
      end else begin
        e = 1'b1;
      end
      if (wav[k - 1] !== e) mism++;
    end
    check({tag, "_wave"}, mism, 0);
    for (int j = 0; j < n; j++) begin
      for (int b = 0; b < 8; b++)
        got[b] = wav[(j * 10 + 1 + b) * C + C / 2 - 1];
      check($sformatf("%s_byte%0d", tag, j), got, exp_q[j]);
    end
  endtask

  task automatic reset_mid_frame();
    model(8'h90, 8'h2C, 8'h64);
    handshake(8'h90, 8'h2C, 8'h64);
    repeat (15 * C + 3) @(negedge clk);
    check("rst_pre_tx", tx, exp_q[1][4]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rdy", mif.msg_ready, 0);
    check("rst_mid_done", bdone, 0);
    rs = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel_rdy", mif.msg_ready, 1);
    check("rst_rel_tx", tx, 1);
  endtask

  initial begin
    logic [7:0] s, prev;
    mif.msg_valid  = 1'b0;
    mif.msg_status = 8'h00;
    mif.msg_data1  = 8'h00;
    mif.msg_data2  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx, 1);
    check("reset_rdy", mif.msg_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", bdone, 0);
    check("reset_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_rdy", mif.msg_ready, 1);
    check("rel_busy", busy, 0);

    send(8'h90, 8'h3C, 8'h64, "note_on");
    send(8'hC5, 8'h12, 8'hFF, "prog");
    send(8'hF8, 8'h00, 8'h00, "clock");
    send(8'h80, 8'hBC, 8'hA5, "note_off");
    send(8'h45, 8'h11, 8'h22, "bad_st");
    reset_mid_frame();
    send(8'h90, 8'h3C, 8'h64, "post_rst");
    send(8'h90, 8'h3E, 8'h64, "rs_a");
    send(8'hF8, 8'h00, 8'h00, "rs_rt");
    send(8'h90, 8'h40, 8'h64, "rs_b");
    send(8'hF6, 8'h00, 8'h00, "rs_clr");
    send(8'h90, 8'h40, 8'h64, "rs_c");

    prev = 8'h90;
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 7) == 0)
        s = 8'($urandom_range(0, 127));
      else if ($urandom_range(0, 2) == 0)
        s = prev;
      else
        s = 8'($urandom_range(128, 255));
      if (s[7]) prev = s;
      send(s, 8'($urandom), 8'($urandom),
           $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
